// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder shared types, scan-code constants
// and the set-2 to ASCII translation function.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
  } key_char_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LSHFT = 8'h12;
  localparam logic [7:0] SC_RSHFT = 8'h59;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_CAPS  = 8'h58;

  function automatic key_char_t set2_to_ascii(
    input logic [7:0] code,
    input logic       ext,
    input logic       shift,
    input logic       caps,
    input logic       ctrl
  );
    key_char_t  r;
    logic       lv;
    logic [4:0] li;
    logic       dv;
    logic [3:0] di;
    logic [7:0] lo;
    logic [7:0] up;
    logic [7:0] sym;
    r   = '0;
    lv  = 1'b0;
    li  = '0;
    dv  = 1'b0;
    di  = '0;
    lo  = '0;
    up  = '0;
    sym = '0;
    if (ext) begin
      case (code)
        8'h75:   r = '{1'b1, 8'h11};
        8'h72:   r = '{1'b1, 8'h12};
        8'h6B:   r = '{1'b1, 8'h13};
        8'h74:   r = '{1'b1, 8'h14};
        default: r = '0;
      endcase
    end else begin
      case (code)
        8'h1C: {lv, li} = {1'b1, 5'd0};
        8'h32: {lv, li} = {1'b1, 5'd1};
        8'h21: {lv, li} = {1'b1, 5'd2};
        8'h23: {lv, li} = {1'b1, 5'd3};
        8'h24: {lv, li} = {1'b1, 5'd4};
        8'h2B: {lv, li} = {1'b1, 5'd5};
        8'h34: {lv, li} = {1'b1, 5'd6};
        8'h33: {lv, li} = {1'b1, 5'd7};
        8'h43: {lv, li} = {1'b1, 5'd8};
        8'h3B: {lv, li} = {1'b1, 5'd9};
        8'h42: {lv, li} = {1'b1, 5'd10};
        8'h4B: {lv, li} = {1'b1, 5'd11};
        8'h3A: {lv, li} = {1'b1, 5'd12};
        8'h31: {lv, li} = {1'b1, 5'd13};
        8'h44: {lv, li} = {1'b1, 5'd14};
        8'h4D: {lv, li} = {1'b1, 5'd15};
        8'h15: {lv, li} = {1'b1, 5'd16};
        8'h2D: {lv, li} = {1'b1, 5'd17};
        8'h1B: {lv, li} = {1'b1, 5'd18};
        8'h2C: {lv, li} = {1'b1, 5'd19};
        8'h3C: {lv, li} = {1'b1, 5'd20};
        8'h2A: {lv, li} = {1'b1, 5'd21};
        8'h1D: {lv, li} = {1'b1, 5'd22};
        8'h22: {lv, li} = {1'b1, 5'd23};
        8'h35: {lv, li} = {1'b1, 5'd24};
        8'h1A: {lv, li} = {1'b1, 5'd25};
        8'h45: {dv, di} = {1'b1, 4'd0};
        8'h16: {dv, di} = {1'b1, 4'd1};
        8'h1E: {dv, di} = {1'b1, 4'd2};
        8'h26: {dv, di} = {1'b1, 4'd3};
        8'h25: {dv, di} = {1'b1, 4'd4};
        8'h2E: {dv, di} = {1'b1, 4'd5};
        8'h36: {dv, di} = {1'b1, 4'd6};
        8'h3D: {dv, di} = {1'b1, 4'd7};
        8'h3E: {dv, di} = {1'b1, 4'd8};
        8'h46: {dv, di} = {1'b1, 4'd9};
        8'h29: r = '{1'b1, 8'h20};
        8'h5A: r = '{1'b1, 8'h0D};
        8'h66: r = '{1'b1, 8'h08};
        8'h0D: r = '{1'b1, 8'h09};
        8'h76: r = '{1'b1, 8'h1B};
        default: r = '0;
      endcase
      case (di)
        4'd0:    sym = 8'h29;
        4'd1:    sym = 8'h21;
        4'd2:    sym = 8'h40;
        4'd3:    sym = 8'h23;
        4'd4:    sym = 8'h24;
        4'd5:    sym = 8'h25;
        4'd6:    sym = 8'h5E;
        4'd7:    sym = 8'h26;
        4'd8:    sym = 8'h2A;
        default: sym = 8'h28;
      endcase
      lo = 8'h61 + {3'b000, li};
      up = lo - 8'h20;
      if (lv) begin
        r.valid = 1'b1;
        if (ctrl)
          r.ch = up & 8'h1F;
        else
          r.ch = (shift ^ caps) ? up : lo;
      end else if (dv) begin
        r.valid = 1'b1;
        r.ch = shift ? sym
                     : 8'h30 + {4'h0, di};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scan-byte input, character read port and
// modifier/overflow status of ps2_key_decoder.
interface ps2_key_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          scan_valid_i;
  logic [7:0]    scan_data_i;
  logic          pop_i;
  logic          clr_ovf_i;
  logic [7:0]    rd_data_o;
  logic          rd_empty_o;
  logic [CW-1:0] rd_count_o;
  logic [2:0]    mod_o;
  logic          overflow_o;

  modport master (
    output scan_valid_i,
    output scan_data_i,
    output pop_i,
    output clr_ovf_i,
    input  rd_data_o,
    input  rd_empty_o,
    input  rd_count_o,
    input  mod_o,
    input  overflow_o
  );

  modport slave (
    input  scan_valid_i,
    input  scan_data_i,
    input  pop_i,
    input  clr_ovf_i,
    output rd_data_o,
    output rd_empty_o,
    output rd_count_o,
    output mod_o,
    output overflow_o
  );
endinterface

// File: rtl/ps2_key_decoder_fifo.sv
// First-word-fall-through FIFO; head reads 0 when
// empty and a pop on an empty FIFO is ignored.
module key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-byte decoder: prefix FSM, modifier
// tracking, registered translate, character FIFO.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic    wb_clk_i,
  input logic    wb_rst_ni,
  ps2_key_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pfx_state_t state_q;
  pfx_state_t state_d;
  logic       make;
  logic       brk;
  logic       ext;
  logic [7:0] code;
  logic       shift_l;
  logic       shift_r;
  logic       ctrl_l;
  logic       ctrl_r;
  logic       caps;
  logic       shift;
  logic       ctrl;
  logic       is_mod;
  key_char_t  xl;
  key_char_t  tr_q;
  logic       full;
  logic [CW-1:0] count;

  assign code  = bus.scan_data_i;
  assign shift = shift_l | shift_r;
  assign ctrl  = ctrl_l | ctrl_r;

  always_comb begin
    state_d = state_q;
    make    = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    if (bus.scan_valid_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (code == SC_EXT)
            state_d = ST_EXT;
          else if (code == SC_BRK)
            state_d = ST_BRK;
          else
            make = 1'b1;
        end
        ST_EXT: begin
          if (code == SC_BRK)
            state_d = ST_EXT_BRK;
          else if (code != SC_EXT) begin
            make    = 1'b1;
            ext     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk     = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk     = 1'b1;
          ext     = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    is_mod = 1'b0;
    unique case (1'b1)
      code == SC_LSHFT: is_mod = 1'b1;
      code == SC_RSHFT: is_mod = 1'b1;
      code == SC_CTRL:  is_mod = 1'b1;
      code == SC_CAPS:  is_mod = 1'b1;
      default:          is_mod = 1'b0;
    endcase
  end

  // Uses modifier state before this byte's own update.
  assign xl = set2_to_ascii(code, ext, shift,
                            caps, ctrl);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      ctrl_l  <= 1'b0;
      ctrl_r  <= 1'b0;
      caps    <= 1'b0;
      tr_q    <= '0;
    end else begin
      state_q <= state_d;
      tr_q    <= '0;
      if (make && !is_mod)
        tr_q <= xl;
      if (make || brk) begin
        if (code == SC_LSHFT)
          shift_l <= make;
        if (code == SC_RSHFT)
          shift_r <= make;
        if (code == SC_CTRL && ext)
          ctrl_r <= make;
        if (code == SC_CTRL && !ext)
          ctrl_l <= make;
        if (code == SC_CAPS && make)
          caps <= ~caps;
      end
    end
  end

  key_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (tr_q.valid),
    .wdata (tr_q.ch),
    .pop   (bus.pop_i),
    .rdata (bus.rd_data_o),
    .empty (bus.rd_empty_o),
    .full  (full),
    .count (count)
  );

  assign bus.rd_count_o = count;
  assign bus.mod_o      = {caps, ctrl, shift};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)
      bus.overflow_o <= 1'b0;
    else if (tr_q.valid && full && !bus.pop_i)
      bus.overflow_o <= 1'b1;
    else if (bus.clr_ovf_i)
      bus.overflow_o <= 1'b0;
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed scoreboard bench for ps2_key_decoder.
module tb_ps2_key_decoder;
  logic clk;
  logic rst_n;
  int   vectors;
  int   fails;
  logic [7:0] sb[$];
  logic [7:0] exp_ch;

  ps2_key_if #(.FIFO_DEPTH(8)) bus ();

  ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.scan_valid_i = 1'b1;
    bus.scan_data_i  = b;
    tick();
    bus.scan_valid_i = 1'b0;
    bus.scan_data_i  = 8'h00;
  endtask

  task automatic pop_chk(input string tag);
    if (sb.size() == 0) begin
      vectors++;
      fails++;
      $error("FAIL %s: got pop want empty sb", tag);
    end else begin
      exp_ch = sb.pop_front();
      chk(tag, bus.rd_data_o, exp_ch);
      bus.pop_i = 1'b1;
      tick();
      bus.pop_i = 1'b0;
    end
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    rst_n            = 1'b0;
    bus.scan_valid_i = 1'b0;
    bus.scan_data_i  = 8'h00;
    bus.pop_i        = 1'b0;
    bus.clr_ovf_i    = 1'b0;
    tick();
    tick();
    chk("rst_empty", 8'(bus.rd_empty_o), 8'h01);
    chk("rst_count", 8'(bus.rd_count_o), 8'h00);
    chk("rst_data", bus.rd_data_o, 8'h00);
    chk("rst_mod", 8'(bus.mod_o), 8'h00);
    chk("rst_ovf", 8'(bus.overflow_o), 8'h00);
    rst_n = 1'b1;
    tick();

    send(8'h1C); sb.push_back(8'h61);
    tick();
    chk("a_count", 8'(bus.rd_count_o), 8'h01);
    chk("a_empty", 8'(bus.rd_empty_o), 8'h00);
    pop_chk("a_data");
    chk("a_pop_empty", 8'(bus.rd_empty_o), 8'h01);
    chk("a_pop_data", bus.rd_data_o, 8'h00);

    send(8'h12);
    chk("shift_mod", 8'(bus.mod_o), 8'h01);
    send(8'h1C); sb.push_back(8'h41);
    send(8'hF0);
    send(8'h12);
    send(8'h1C); sb.push_back(8'h61);
    tick();
    chk("shift_mod0", 8'(bus.mod_o), 8'h00);
    chk("shift_cnt", 8'(bus.rd_count_o), 8'h02);
    pop_chk("shift_A");
    pop_chk("shift_a");

    send(8'h58);
    chk("caps_mod", 8'(bus.mod_o), 8'h04);
    send(8'hF0);
    send(8'h58);
    send(8'h16); sb.push_back(8'h31);
    tick();
    chk("caps_brk_mod", 8'(bus.mod_o), 8'h04);
    pop_chk("caps_digit");

    send(8'h59);
    chk("rshift_mod", 8'(bus.mod_o), 8'h05);
    send(8'h1C); sb.push_back(8'h61);
    send(8'hF0);
    send(8'h59);
    send(8'hE0);
    send(8'h14);
    chk("rctrl_mod", 8'(bus.mod_o), 8'h06);
    send(8'h21); sb.push_back(8'h03);
    send(8'hE0);
    send(8'hF0);
    send(8'h14);
    send(8'hE0);
    send(8'h75); sb.push_back(8'h11);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'h12);
    send(8'h16); sb.push_back(8'h21);
    send(8'hF0);
    send(8'h12);
    tick();
    chk("mix_cnt", 8'(bus.rd_count_o), 8'h04);
    pop_chk("caps_shift_a");
    pop_chk("ctrl_c");
    pop_chk("ext_up");
    pop_chk("shift_1");
    send(8'h58);
    chk("caps_off", 8'(bus.mod_o), 8'h00);

    send(8'h1C); sb.push_back(8'h61);
    send(8'h32); sb.push_back(8'h62);
    send(8'h21); sb.push_back(8'h63);
    send(8'h23); sb.push_back(8'h64);
    send(8'h24); sb.push_back(8'h65);
    send(8'h2B); sb.push_back(8'h66);
    send(8'h34); sb.push_back(8'h67);
    send(8'h33); sb.push_back(8'h68);
    send(8'h43);
    tick();
    chk("full_cnt", 8'(bus.rd_count_o), 8'h08);
    chk("full_ovf", 8'(bus.overflow_o), 8'h01);
    chk("full_head", bus.rd_data_o, 8'h61);
    bus.clr_ovf_i = 1'b1;
    tick();
    bus.clr_ovf_i = 1'b0;
    chk("clr_ovf", 8'(bus.overflow_o), 8'h00);
    send(8'h44);
    exp_ch = sb.pop_front();
    chk("pp_head", bus.rd_data_o, exp_ch);
    sb.push_back(8'h6F);
    bus.pop_i = 1'b1;
    tick();
    bus.pop_i = 1'b0;
    chk("pp_cnt", 8'(bus.rd_count_o), 8'h08);
    chk("pp_ovf", 8'(bus.overflow_o), 8'h00);
    for (int i = 0; i < 8; i++)
      pop_chk("drain");
    chk("drain_empty", 8'(bus.rd_empty_o), 8'h01);

    send(8'h07);
    send(8'hF0);
    send(8'h1C);
    send(8'h29); sb.push_back(8'h20);
    send(8'h5A); sb.push_back(8'h0D);
    tick();
    chk("unmap_cnt", 8'(bus.rd_count_o), 8'h02);
    pop_chk("space");
    pop_chk("enter");

    send(8'h12);
    send(8'hE0);
    rst_n = 1'b0;
    #3;
    chk("arst_mod", 8'(bus.mod_o), 8'h00);
    chk("arst_empty", 8'(bus.rd_empty_o), 8'h01);
    rst_n = 1'b1;
    tick();
    send(8'h1C); sb.push_back(8'h61);
    tick();
    chk("arst_cnt", 8'(bus.rd_count_o), 8'h01);
    pop_chk("arst_a");
    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream of the PS/2 keyboard receiver, and upstream of the keyboard Wishbone register wrapper. Consumes raw PS/2 scan-code set 2 bytes, one per `scan_valid_i` strobe, and tracks the E0/F0 prefixes and the shift/ctrl/caps modifier state. It translates make codes to 8-bit ASCII/control characters and buffers them in a first-word-fall-through FIFO for software to pop. Break codes and modifier keys update state only; they never enter the FIFO.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8. Character FIFO entries; must be a power of two, ≥2.

Ports:
- `wb_clk_i`  in  1  single clock for the whole block.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `scan_valid_i`  in  1  one-cycle strobe; `scan_data_i` valid this cycle.
- `scan_data_i`  in  8  raw set-2 byte.
- `pop_i`  in  1  remove head entry; ignored when `rd_empty_o`=1.
- `rd_data_o`  out  8  FIFO head character (FWFT); 0x00 when empty.
- `rd_empty_o`  out  1  FIFO empty.
- `rd_count_o`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `mod_o`  out  3  {caps_lock, ctrl, shift} current state.
- `overflow_o`  out  1  sticky; a character was dropped because the FIFO was full.
- `clr_ovf_i`  in  1  clears `overflow_o`.

## Operation
- Reset values:
  - `rd_empty_o`=1, `rd_count_o`=0, `rd_data_o`=0x00, `mod_o`=0, `overflow_o`=0.
  - Prefix FSM = IDLE.
- Prefix FSM (advances only on `scan_valid_i`):
  - IDLE: E0→EXT, F0→BRK, else make(code, ext=0)→IDLE.
  - EXT: F0→EXT_BRK, E0→EXT, else make(code, ext=1)→IDLE.
  - BRK: break(code, ext=0)→IDLE.
  - EXT_BRK: break(code, ext=1)→IDLE.
- Modifiers:
  - 0x12/0x59 make sets shift; break clears it. Each shift key is tracked separately; `shift` = OR of both.
  - 0x14 make/break sets/clears ctrl, with or without the E0 prefix. Left and right ctrl are tracked separately and ORed.
  - 0x58 make toggles caps_lock; its break does nothing. Typematic repeat (make without an intervening break) toggles it again.
- Translation: applied to non-modifier makes only.
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a–z. Output is uppercase iff shift XOR caps_lock.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 0–9. With shift they map to `)!@#$%^&*(`.
  - 29→0x20, 5A→0x0D, 66→0x08, 0D→0x09, 76→0x1B.
  - Extended E0 75/72/6B/74 → 0x11/0x12/0x13/0x14 (up/down/left/right).
  - Ctrl overrides: a letter with ctrl emits (uppercase & 0x1F).
  - Unmapped codes, including E0-prefixed codes not listed above, are discarded silently.
- FIFO:
  - A push happens when the translate stage produces a character.
  - On push when full and no pop in the same cycle: the character is dropped and `overflow_o` is set.
  - On push and pop in the same cycle when full: both happen, with no overflow.
  - On push and pop in the same cycle when empty: the pop is ignored and the push lands.
  - If `clr_ovf_i` and a new overflow occur in the same cycle, the overflow wins (set).
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Translate stage is registered. A byte sampled at edge N has its character written at edge N+1. `rd_empty_o` falls and `rd_data_o` is valid after edge N+1.
- Back-to-back `scan_valid_i` on consecutive cycles is supported at full rate.
- `mod_o` updates at edge N, the edge that samples the modifier byte.
- Modifier state is applied as it stands when the translate stage is loaded at edge N. A modifier make and the following character may therefore be on consecutive cycles.
- A pop at edge M advances `rd_data_o` and `rd_count_o` after edge M.
- Asserting `wb_rst_ni` low at any time immediately clears the FSM, modifiers, pending translate register, FIFO and overflow flag. A half-received prefix sequence is lost.

## Structure
- Package `ps2_key_pkg`:
  - prefix FSM state enum;
  - constants SC_EXT=0xE0, SC_BRK=0xF0, and the modifier codes;
  - function `set2_to_ascii(code, ext, shift, caps, ctrl)` returning {valid, char}.
- Sub-module `key_fifo`: a synchronous FWFT FIFO parameterised by width and depth, with count and full/empty outputs. The top level holds the FSM, the modifier registers and the translate register.

## Test plan
- Reset, then bytes 1C: `rd_data_o`=0x61, `rd_count_o`=1, `rd_empty_o`=0 two cycles after the strobe. Pop → `rd_empty_o`=1, `rd_data_o`=0x00.
- 12, 1C, F0 12, 1C → FIFO holds 0x41 then 0x61, `mod_o` ends at 0. Then 58, F0 58, 16 → 0x31, with `mod_o`=3'b100.
- Caps on + shift held + 1C → 0x61. E0 14 + 21 → 0x03. E0 75 → 0x11. E0 F0 75 → nothing pushed.
- With FIFO_DEPTH=8, push 9 chars with no pop: count=8, `overflow_o`=1, head is the first char. `clr_ovf_i` → 0. Full + simultaneous push/pop → count stays 8, `overflow_o` stays 0.
- Unmapped make 0x07 and break F0 1C → no push. Bytes on consecutive cycles 1C 32 21 → 0x61, 0x62, 0x63 in order.
- Send E0, then pulse reset low, then 1C → single 0x61 (not treated as extended). `mod_o`=0 after reset even if shift was held.
